// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// memory wait states, deferred branch flush, saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_all_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic [1:0]       busy_state_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] count_q;

  logic load_use, mem_hold, br;
  logic s_if, s_id, s_all, f_id, f_ex;

  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  assign mem_hold = mem_req_i && !mem_ready_i;
  assign br       = ex_branch_taken_i || pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    s_if    = 1'b0;
    s_id    = 1'b0;
    s_all   = 1'b0;
    f_id    = 1'b0;
    f_ex    = 1'b0;
    unique case (1'b1)
      (state_q == FLUSH): begin
        if (mem_hold) begin
          s_all = 1'b1;
          s_if  = 1'b1;
          s_id  = 1'b1;
        end else begin
          f_id  = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_d = RUN;
        end
      end
      (state_q == MEM_WAIT) && mem_hold: begin
        s_all = 1'b1;
        s_if  = 1'b1;
        s_id  = 1'b1;
      end
      // RUN, MEM_WAIT release cycle, and the illegal encoding
      default: begin
        state_d = RUN;
        if (mem_hold) begin
          s_all   = 1'b1;
          s_if    = 1'b1;
          s_id    = 1'b1;
          pend_d  = br;
          state_d = MEM_WAIT;
        end else if (br) begin
          f_id   = 1'b1;
          f_ex   = 1'b1;
          pend_d = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
          end
        end else if (load_use) begin
          s_if = 1'b1;
          s_id = 1'b1;
          f_ex = 1'b1;
        end
      end
    endcase
  end

  assign stall_if_o   = s_if  && !rst_i;
  assign stall_id_o   = s_id  && !rst_i;
  assign stall_all_o  = s_all && !rst_i;
  assign flush_id_o   = f_id  && !rst_i;
  assign flush_ex_o   = f_ex  && !rst_i;
  assign busy_state_o = state_q;
  assign stall_count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (stall_if_o && (count_q != {CNT_W{1'b1}}))
        count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0, branch flush,
// memory wait, collision, reset mid-wait, counter saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       use1, use2, ex_mr, br, mreq, mrdy;
  logic       s_if, s_id, s_all, f_id, f_ex;
  logic [1:0] bs;
  logic [3:0] cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .id_use_rs1_i     (use1),
    .id_use_rs2_i     (use2),
    .ex_mem_read_i    (ex_mr),
    .ex_rd_i          (ex_rd),
    .ex_branch_taken_i(br),
    .mem_req_i        (mreq),
    .mem_ready_i      (mrdy),
    .stall_if_o       (s_if),
    .stall_id_o       (s_id),
    .stall_all_o      (s_all),
    .flush_id_o       (f_id),
    .flush_ex_o       (f_ex),
    .busy_state_o     (bs),
    .stall_count_o    (cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {stall_if, stall_id, stall_all, flush_id, flush_ex, busy[1:0]}
  task automatic cyc(input string tag, input logic [6:0] exp);
    #1;
    check(tag, {25'd0, s_if, s_id, s_all, f_id, f_ex, bs}, {25'd0, exp});
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; ex_mr = 1'b0;
    br = 1'b0; mreq = 1'b0; mrdy = 1'b1;
  endtask

  task automatic hold();
    mreq = 1'b1; mrdy = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    br = 1'b1; hold();
    cyc("rst_out", 7'b0000000);
    @(negedge clk);
    rst = 1'b0; idle();
    cyc("post_rst", 7'b0000000);
    check("cnt_rst", {28'd0, cnt}, 32'd0);

    // load-use on rs1
    @(negedge clk);
    ex_mr = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use1 = 1'b1;
    cyc("lu_rs1", 7'b1100100);
    @(negedge clk);
    ex_mr = 1'b0;
    cyc("lu_after", 7'b0000000);
    check("cnt_lu", {28'd0, cnt}, 32'd1);

    // x0 destination never stalls
    @(negedge clk);
    ex_mr = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; use1 = 1'b1;
    cyc("lu_x0", 7'b0000000);

    // rs2 match, then same regs but unused
    @(negedge clk);
    idle(); ex_mr = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; use2 = 1'b1;
    cyc("lu_rs2", 7'b1100100);
    @(negedge clk);
    use2 = 1'b0;
    cyc("lu_nouse", 7'b0000000);
    check("cnt_rs2", {28'd0, cnt}, 32'd2);

    // taken branch: flush then one FLUSH cycle
    @(negedge clk);
    idle(); br = 1'b1;
    cyc("br_n", 7'b0001100);
    @(negedge clk);
    br = 1'b0;
    cyc("br_n1", 7'b0001010);
    @(negedge clk);
    cyc("br_n2", 7'b0000000);

    // branch beats load-use
    @(negedge clk);
    br = 1'b1; ex_mr = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; use1 = 1'b1;
    cyc("br_lu", 7'b0001100);
    @(negedge clk);
    idle();
    cyc("br_lu_fl", 7'b0001010);

    // 3-cycle memory wait
    @(negedge clk);
    hold();
    cyc("mw_1", 7'b1110000);
    @(negedge clk);
    cyc("mw_2", 7'b1110001);
    @(negedge clk);
    cyc("mw_3", 7'b1110001);
    @(negedge clk);
    mrdy = 1'b1;
    cyc("mw_rel", 7'b0000001);
    check("cnt_mw", {28'd0, cnt}, 32'd5);
    @(negedge clk);
    idle();
    cyc("mw_run", 7'b0000000);

    // branch colliding with memory wait is deferred
    @(negedge clk);
    br = 1'b1; hold();
    cyc("col_1", 7'b1110000);
    @(negedge clk);
    cyc("col_2", 7'b1110001);
    @(negedge clk);
    br = 1'b0; mrdy = 1'b1;
    cyc("col_rel", 7'b0001101);
    @(negedge clk);
    idle();
    cyc("col_fl", 7'b0001010);
    @(negedge clk);
    cyc("col_run", 7'b0000000);
    check("cnt_col", {28'd0, cnt}, 32'd7);

    // memory wait inside FLUSH freezes the counter
    @(negedge clk);
    br = 1'b1;
    cyc("fm_br", 7'b0001100);
    @(negedge clk);
    br = 1'b0; hold();
    cyc("fm_h1", 7'b1110010);
    @(negedge clk);
    cyc("fm_h2", 7'b1110010);
    @(negedge clk);
    idle(); br = 1'b1;
    cyc("fm_rel", 7'b0001010);
    @(negedge clk);
    br = 1'b0;
    cyc("fm_run", 7'b0000000);
    check("cnt_fm", {28'd0, cnt}, 32'd9);

    // reset during MEM_WAIT drops the pending branch
    @(negedge clk);
    br = 1'b1; hold();
    cyc("rw_1", 7'b1110000);
    @(negedge clk);
    rst = 1'b1;
    cyc("rw_rst", 7'b0000001);
    @(negedge clk);
    rst = 1'b0; idle();
    cyc("rw_after", 7'b0000000);
    check("cnt_rw", {28'd0, cnt}, 32'd0);
    @(negedge clk);
    cyc("rw_noflush", 7'b0000000);

    // saturation: 20 stall cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hold();
    end
    @(negedge clk);
    mrdy = 1'b1;
    cyc("sat_rel", 7'b0000001);
    check("cnt_sat", {28'd0, cnt}, 32'd15);
    @(negedge clk);
    idle();
    cyc("sat_run", 7'b0000000);
    check("cnt_hold", {28'd0, cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
